fetch: RTL and testbench

//  Instruction fetch unit and Wishbone B4 classic master for the instruction port.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch.sv | 171 +++++++++++++++++
 tb/tb_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: Wishbone instruction-port and decoder-side signals of the fetch unit.
// master = fetch unit, slave = bus slave plus decoder/redirect environment.
interface fetch_if;
    logic        cyc_o;
    logic        stb_o;
    logic [63:0] adr_o;
    logic        ack_i;
    logic        err_i;
    logic [31:0] dat_i;
    logic        pc_load_i;
    logic [63:0] pc_i;
    logic        ir_take_i;
    logic        ir_valid_o;
    logic [31:0] ir_o;
    logic [63:0] ir_pc_o;
    logic        ir_fault_o;

    modport master (
        output cyc_o, stb_o, adr_o,
        input  ack_i, err_i, dat_i,
        input  pc_load_i, pc_i, ir_take_i,
        output ir_valid_o, ir_o, ir_pc_o, ir_fault_o
    );

    modport slave (
        input  cyc_o, stb_o, adr_o,
        output ack_i, err_i, dat_i,
        output pc_load_i, pc_i, ir_take_i,
        input  ir_valid_o, ir_o, ir_pc_o, ir_fault_o
    );
endinterface

// File: rtl/fetch.sv
// fetch: instruction fetch unit, Wishbone B4 classic master feeding a small prefetch queue.
// Optional macro FETCH_ERR_EN: bus errors push faulting entries and halt fetching until redirect.
module fetch #(
    parameter logic [63:0] RESET_PC    = 64'hFFFF_FFFF_FFFF_FF00,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    reset_i,
    fetch_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_cyc;
    logic [63:0]   r_adr;
    logic [63:0]   r_fpc;
    logic          r_stopped;
    logic [31:0]   r_q_dat [QUEUE_DEPTH];
    logic [63:0]   r_q_pc  [QUEUE_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_err;
    logic          w_term;
    logic          w_push;
    logic          w_pop;
    logic          w_room;
    logic [CW-1:0] w_count_nxt;
    logic [63:0]   w_target;

`ifdef FETCH_ERR_EN
    logic          r_q_flt [QUEUE_DEPTH];
    assign w_err          = bus.err_i;
    assign bus.ir_fault_o = r_q_flt[r_rptr];
`else
    // err_i has no effect in this build
    assign w_err          = bus.err_i & 1'b0;
    assign bus.ir_fault_o = 1'b0;
`endif

    assign bus.cyc_o      = r_cyc;
    assign bus.stb_o      = r_cyc;
    assign bus.adr_o      = r_adr;
    assign bus.ir_valid_o = (r_count != {CW{1'b0}});
    assign bus.ir_o       = r_q_dat[r_rptr];
    assign bus.ir_pc_o    = r_q_pc[r_rptr];

    // Bus termination, queue push/pop and next occupancy
    always_comb begin
        w_target    = bus.pc_i & ~64'd3;
        w_term      = (r_state != S_IDLE) & r_cyc & (bus.ack_i | w_err);
        w_push      = (r_state == S_FETCH) & w_term & ~bus.pc_load_i;
        w_pop       = bus.ir_valid_o & bus.ir_take_i;
        w_count_nxt = r_count;
        if (bus.pc_load_i) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
        w_room = (w_count_nxt < FULL);
    end

    // Fetch FSM with registered Wishbone outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_cyc     <= 1'b0;
            r_adr     <= RESET_PC;
            r_fpc     <= RESET_PC;
            r_stopped <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.pc_load_i) begin
                        r_fpc     <= w_target;
                        r_adr     <= w_target;
                        r_cyc     <= 1'b1;
                        r_stopped <= 1'b0;
                        r_state   <= S_FETCH;
                    end else if (w_room && !r_stopped) begin
                        r_adr   <= r_fpc;
                        r_cyc   <= 1'b1;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH, S_DRAIN: begin
                    if (bus.pc_load_i) begin
                        // Redirect: an outstanding request must still be drained
                        r_fpc     <= w_target;
                        r_stopped <= 1'b0;
                        if (w_term) begin
                            r_adr   <= w_target;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_term && r_state == S_DRAIN) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_term && w_err) begin
                        r_cyc     <= 1'b0;
                        r_stopped <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_term) begin
                        r_fpc <= r_fpc + 64'd4;
                        if (w_room) begin
                            r_adr <= r_fpc + 64'd4;
                        end else begin
                            r_cyc   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Prefetch queue storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_dat[i] <= 32'h0;
                r_q_pc[i]  <= 64'h0;
`ifdef FETCH_ERR_EN
                r_q_flt[i] <= 1'b0;
`endif
            end
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (bus.pc_load_i) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_q_dat[r_wptr] <= w_err ? 32'h0 : bus.dat_i;
                r_q_pc[r_wptr]  <= r_fpc;
`ifdef FETCH_ERR_EN
                r_q_flt[r_wptr] <= w_err;
`endif
                r_wptr <= r_wptr + PW'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end else begin
                r_rptr <= r_rptr;
            end
            r_count <= w_count_nxt;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for the fetch unit with a Wishbone slave model of configurable wait states.
// Slave data: RESET_PC returns 32'h00100093, any other address returns adr[31:0] ^ 32'h1111_0000.
module tb_fetch;
    localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FF00;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   wait_cfg;
    int   wcnt;
    int   ack_cnt;
    logic ack_en;
    logic err_mode;

    fetch_if bus ();

    fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ack_i = bus.stb_o & ack_en & (wcnt >= wait_cfg);
    assign bus.err_i = bus.stb_o & err_mode;
    assign bus.dat_i = (bus.adr_o == RPC) ? 32'h0010_0093 : (bus.adr_o[31:0] ^ 32'h1111_0000);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= 0;
            ack_cnt <= 0;
        end else begin
            if (bus.stb_o && !bus.ack_i) wcnt <= wcnt + 1;
            else                         wcnt <= 0;
            if (bus.stb_o && bus.ack_i)  ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; wait_cfg = 0; ack_en = 1'b1; err_mode = 1'b0;
        bus.pc_load_i = 1'b0; bus.pc_i = 64'h0; bus.ir_take_i = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_cyc",   {63'h0, bus.cyc_o}, 64'h0);
        check("rst_adr",   bus.adr_o, RPC);
        check("rst_valid", {63'h0, bus.ir_valid_o}, 64'h0);
        check("rst_ir",    {32'h0, bus.ir_o}, 64'h0);
        check("rst_irpc",  bus.ir_pc_o, 64'h0);
        check("rst_fault", {63'h0, bus.ir_fault_o}, 64'h0);
        rst_n = 1'b1;

        // 1: first fetch after reset
        @(negedge clk);
        check("t1_stb", {63'h0, bus.stb_o}, 64'h1);
        check("t1_adr", bus.adr_o, RPC);
        @(negedge clk);
        check("t1_valid", {63'h0, bus.ir_valid_o}, 64'h1);
        check("t1_ir",    {32'h0, bus.ir_o}, 64'h0000_0000_0010_0093);
        check("t1_irpc",  bus.ir_pc_o, RPC);
        check("t1_adr2",  bus.adr_o, 64'hFFFF_FFFF_FFFF_FF04);

        // 2: queue fills after two acks and fetching pauses
        @(negedge clk);
        check("t2_cyc0", {63'h0, bus.cyc_o}, 64'h0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t2_cyc_idle", {63'h0, bus.cyc_o}, 64'h0);
        check("t2_acks", 64'(ack_cnt), 64'd2);
        check("t2_head", bus.ir_pc_o, RPC);
        bus.ir_take_i = 1'b1;
        @(negedge clk);
        bus.ir_take_i = 1'b0;
        check("t2_stb",    {63'h0, bus.stb_o}, 64'h1);
        check("t2_adr",    bus.adr_o, 64'hFFFF_FFFF_FFFF_FF08);
        check("t2_head_ir", {32'h0, bus.ir_o}, 64'h0000_0000_EEEE_FF04);
        check("t2_head_pc", bus.ir_pc_o, 64'hFFFF_FFFF_FFFF_FF04);
        @(negedge clk);
        check("t2_cyc_full", {63'h0, bus.cyc_o}, 64'h0);
        check("t2_acks3",    64'(ack_cnt), 64'd3);

        // 3: redirect during a 3-wait-state fetch drains the old cycle
        wait_cfg = 3;
        bus.ir_take_i = 1'b1;
        @(negedge clk);
        bus.ir_take_i = 1'b0;
        check("t3_adr_old", bus.adr_o, 64'hFFFF_FFFF_FFFF_FF0C);
        check("t3_ack0",    {63'h0, bus.ack_i}, 64'h0);
        @(negedge clk);
        bus.pc_load_i = 1'b1; bus.pc_i = 64'h1003;
        @(negedge clk);
        bus.pc_load_i = 1'b0;
        check("t3_flush",     {63'h0, bus.ir_valid_o}, 64'h0);
        check("t3_drain_stb", {63'h0, bus.stb_o}, 64'h1);
        check("t3_drain_adr", bus.adr_o, 64'hFFFF_FFFF_FFFF_FF0C);
        @(negedge clk);
        check("t3_drain_ack", {63'h0, bus.ack_i}, 64'h1);
        @(negedge clk);
        check("t3_idle_cyc", {63'h0, bus.cyc_o}, 64'h0);
        check("t3_dropped",  {63'h0, bus.ir_valid_o}, 64'h0);
        wait_cfg = 0;
        @(negedge clk);
        check("t3_new_stb", {63'h0, bus.stb_o}, 64'h1);
        check("t3_new_adr", bus.adr_o, 64'h1000);
        @(negedge clk);
        check("t3_irpc", bus.ir_pc_o, 64'h1000);
        check("t3_ir",   {32'h0, bus.ir_o}, 64'h0000_0000_1111_1000);
        @(negedge clk);
        check("t3_full_cyc", {63'h0, bus.cyc_o}, 64'h0);

        // 4: redirect, ack and take in the same cycle
        bus.ir_take_i = 1'b1;
        @(negedge clk);
        check("t4_adr", bus.adr_o, 64'h1008);
        check("t4_ack", {63'h0, bus.ack_i}, 64'h1);
        bus.ir_take_i = 1'b1; bus.pc_load_i = 1'b1; bus.pc_i = 64'h3000;
        @(negedge clk);
        bus.ir_take_i = 1'b0; bus.pc_load_i = 1'b0;
        check("t4_empty",   {63'h0, bus.ir_valid_o}, 64'h0);
        check("t4_new_adr", bus.adr_o, 64'h3000);
        check("t4_new_stb", {63'h0, bus.stb_o}, 64'h1);
        @(negedge clk);
        check("t4_valid", {63'h0, bus.ir_valid_o}, 64'h1);
        check("t4_irpc",  bus.ir_pc_o, 64'h3000);
        check("t4_ir",    {32'h0, bus.ir_o}, 64'h0000_0000_1111_3000);
        @(negedge clk);

        // 5: 64-bit address wrap
        bus.pc_load_i = 1'b1; bus.pc_i = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        bus.pc_load_i = 1'b0;
        check("t5_adr_f8", bus.adr_o, 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk);
        check("t5_adr_fc", bus.adr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_pc_f8",  bus.ir_pc_o, 64'hFFFF_FFFF_FFFF_FFF8);
        check("t5_ir_f8",  {32'h0, bus.ir_o}, 64'h0000_0000_EEEE_FFF8);
        @(negedge clk);
        bus.ir_take_i = 1'b1;
        @(negedge clk);
        bus.ir_take_i = 1'b0;
        check("t5_adr_0", bus.adr_o, 64'h0);
        check("t5_pc_fc", bus.ir_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_ir_fc", {32'h0, bus.ir_o}, 64'h0000_0000_EEEE_FFFC);
        @(negedge clk);
        bus.ir_take_i = 1'b1;
        @(negedge clk);
        bus.ir_take_i = 1'b0;
        check("t5_pc_0",    bus.ir_pc_o, 64'h0);
        check("t5_ir_0",    {32'h0, bus.ir_o}, 64'h0000_0000_1111_0000);
        check("t5_fault_0", {63'h0, bus.ir_fault_o}, 64'h0);
        check("t5_adr_4",   bus.adr_o, 64'h4);
        @(negedge clk);

        // 6: bus error at 0x2000
        err_mode = 1'b1;
`ifdef FETCH_ERR_EN
        ack_en = 1'b0;
`endif
        bus.pc_load_i = 1'b1; bus.pc_i = 64'h2000;
        @(negedge clk);
        bus.pc_load_i = 1'b0;
        check("t6_adr", bus.adr_o, 64'h2000);
        @(negedge clk);
        err_mode = 1'b0; ack_en = 1'b1;
        check("t6_valid", {63'h0, bus.ir_valid_o}, 64'h1);
        check("t6_irpc",  bus.ir_pc_o, 64'h2000);
`ifdef FETCH_ERR_EN
        check("t6_fault", {63'h0, bus.ir_fault_o}, 64'h1);
        check("t6_ir",    {32'h0, bus.ir_o}, 64'h0);
        check("t6_cyc",   {63'h0, bus.cyc_o}, 64'h0);
        bus.ir_take_i = 1'b1;
        @(negedge clk);
        bus.ir_take_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_stopped", {63'h0, bus.stb_o}, 64'h0);
            @(negedge clk);
        end
        bus.pc_load_i = 1'b1; bus.pc_i = 64'h2100;
        @(negedge clk);
        bus.pc_load_i = 1'b0;
        check("t6_restart_stb", {63'h0, bus.stb_o}, 64'h1);
        check("t6_restart_adr", bus.adr_o, 64'h2100);
`else
        check("t6_fault", {63'h0, bus.ir_fault_o}, 64'h0);
        check("t6_ir",    {32'h0, bus.ir_o}, 64'h0000_0000_1111_2000);
        check("t6_stb",   {63'h0, bus.stb_o}, 64'h1);
        check("t6_adr2",  bus.adr_o, 64'h2004);
`endif

        // Asynchronous reset in the middle of a bus cycle
        #2 rst_n = 1'b0;
        #1;
        check("ar_cyc",   {63'h0, bus.cyc_o}, 64'h0);
        check("ar_stb",   {63'h0, bus.stb_o}, 64'h0);
        check("ar_valid", {63'h0, bus.ir_valid_o}, 64'h0);
        check("ar_adr",   bus.adr_o, RPC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
